// File: rtl/cmp_track_if.sv
// Sample-stream bundle for cmp_track: one unsigned sample in per cycle, tracked
// history, extremes and magnitude flags out, plus the tracker's state for observation.
interface cmp_track_if #(
  parameter int CMP_WIDTH = 4
);
  // No valid/ready handshake: the producer drives a defined cmp_in_a every cycle,
  // and every rising clk edge consumes it unconditionally.
  logic [CMP_WIDTH-1:0] cmp_in_a;
  logic [CMP_WIDTH-1:0] cmp_out;
  logic [CMP_WIDTH-1:0] cmp_b;
  logic [CMP_WIDTH-1:0] cmp_min;
  logic                 cmp_gt;
  logic                 cmp_eq;
  logic                 cmp_lt;
  logic                 first_seen;

  modport master (
    output cmp_in_a,
    input  cmp_out, cmp_b, cmp_min, cmp_gt, cmp_eq, cmp_lt, first_seen
  );

  modport slave (
    input  cmp_in_a,
    output cmp_out, cmp_b, cmp_min, cmp_gt, cmp_eq, cmp_lt, first_seen
  );
endinterface

// File: rtl/cmp_track.sv
// Registered unsigned sample tracker: previous sample, running max/min and
// one-hot gt/eq/lt flags of each new sample against the one before it.
module cmp_track #(
  parameter int CMP_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  cmp_track_if.slave  bus
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_TRACK = 1'b1;
  localparam logic [CMP_WIDTH-1:0] ALL_ONES = '1;

  logic [0:0]           state;
  logic [CMP_WIDTH-1:0] max_q;
  logic [CMP_WIDTH-1:0] prev_q;
  logic [CMP_WIDTH-1:0] min_q;
  logic                 gt_q;
  logic                 eq_q;
  logic                 lt_q;

  // Empty max/min start at 0 / all ones, so the first sample always loads both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_EMPTY;
      max_q  <= '0;
      prev_q <= '0;
      min_q  <= ALL_ONES;
      gt_q   <= 1'b0;
      eq_q   <= 1'b0;
      lt_q   <= 1'b0;
    end else begin
      prev_q <= bus.cmp_in_a;
      if (bus.cmp_in_a > max_q) max_q <= bus.cmp_in_a;
      if (bus.cmp_in_a < min_q) min_q <= bus.cmp_in_a;
      // prev_q is meaningless until one sample has been captured.
      if (state == ST_TRACK) begin
        gt_q <= (bus.cmp_in_a >  prev_q);
        eq_q <= (bus.cmp_in_a == prev_q);
        lt_q <= (bus.cmp_in_a <  prev_q);
      end else begin
        gt_q <= 1'b0;
        eq_q <= 1'b0;
        lt_q <= 1'b0;
      end
      state <= ST_TRACK;
    end
  end

  assign bus.cmp_out    = max_q;
  assign bus.cmp_b      = prev_q;
  assign bus.cmp_min    = min_q;
  assign bus.cmp_gt     = gt_q;
  assign bus.cmp_eq     = eq_q;
  assign bus.cmp_lt     = lt_q;
  assign bus.first_seen = (state == ST_TRACK);

endmodule

// File: tb/tb_cmp_track.sv
// Bench for cmp_track: directed vector table, reset corner sequences, and random
// samples against a history-queue reference model.
module tb_cmp_track;

  localparam int W = 4;
  localparam logic [W-1:0] ONES = '1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] exp_b;
    logic [W-1:0] exp_out;
    logic [W-1:0] exp_min;
    logic [2:0]   exp_flags;  // {gt, eq, lt}
  } vec_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  // Every sample captured since the last reset, oldest first.
  logic [W-1:0] exp_q[$];

  cmp_track_if #(.CMP_WIDTH(W)) bus ();

  cmp_track #(.CMP_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_max();
    logic [W-1:0] m;
    m = '0;
    foreach (exp_q[i]) if (exp_q[i] > m) m = exp_q[i];
    return m;
  endfunction

  function automatic logic [W-1:0] model_min();
    logic [W-1:0] m;
    m = ONES;
    foreach (exp_q[i]) if (exp_q[i] < m) m = exp_q[i];
    return m;
  endfunction

  function automatic logic [W-1:0] model_prev();
    if (exp_q.size() == 0) return '0;
    return exp_q[exp_q.size()-1];
  endfunction

  function automatic logic [2:0] model_flags();
    logic [W-1:0] cur;
    logic [W-1:0] old;
    if (exp_q.size() < 2) return 3'b000;
    cur = exp_q[exp_q.size()-1];
    old = exp_q[exp_q.size()-2];
    if (cur > old) return 3'b100;
    if (cur == old) return 3'b010;
    return 3'b001;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] dut_flags();
    return {bus.cmp_gt, bus.cmp_eq, bus.cmp_lt};
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".b"},     32'(bus.cmp_b),   32'(model_prev()));
    check({tag, ".max"},   32'(bus.cmp_out), 32'(model_max()));
    check({tag, ".min"},   32'(bus.cmp_min), 32'(model_min()));
    check({tag, ".flags"}, 32'(dut_flags()), 32'(model_flags()));
    if (exp_q.size() > 0) begin
      check({tag, ".min_le_max"}, 32'(bus.cmp_min <= bus.cmp_out), 32'd1);
      if (exp_q.size() > 1)
        check({tag, ".onehot"}, 32'($countones(dut_flags())), 32'd1);
    end
  endtask

  // ---------------- drivers ----------------
  // Called just after a falling edge; drives, lets one rising edge capture,
  // and returns at the next falling edge where outputs are stable.
  task automatic apply_sample(input logic [W-1:0] a);
    bus.cmp_in_a = a;
    @(posedge clk);
    exp_q.push_back(a);
    @(negedge clk);
  endtask

  // Raises rst between edges and checks the clear happens with no clock edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check_model({tag, ".async"});
    @(posedge clk);
    @(negedge clk);
    check_model({tag, ".held"});
    rst = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t vecs[7];

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    vecs[0] = '{a: 4'h1, exp_b: 4'h1, exp_out: 4'h1, exp_min: 4'h1, exp_flags: 3'b000};
    vecs[1] = '{a: 4'h3, exp_b: 4'h3, exp_out: 4'h3, exp_min: 4'h1, exp_flags: 3'b100};
    vecs[2] = '{a: 4'h2, exp_b: 4'h2, exp_out: 4'h3, exp_min: 4'h1, exp_flags: 3'b001};
    vecs[3] = '{a: 4'h2, exp_b: 4'h2, exp_out: 4'h3, exp_min: 4'h1, exp_flags: 3'b010};
    vecs[4] = '{a: 4'hF, exp_b: 4'hF, exp_out: 4'hF, exp_min: 4'h1, exp_flags: 3'b100};
    vecs[5] = '{a: 4'h0, exp_b: 4'h0, exp_out: 4'hF, exp_min: 4'h0, exp_flags: 3'b001};
    vecs[6] = '{a: 4'h7, exp_b: 4'h7, exp_out: 4'hF, exp_min: 4'h0, exp_flags: 3'b100};

    // Reset held for two edges with a live input.
    rst = 1'b1;
    bus.cmp_in_a = 4'h5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.out",   32'(bus.cmp_out), 32'h0);
    check("rst.b",     32'(bus.cmp_b),   32'h0);
    check("rst.min",   32'(bus.cmp_min), 32'(ONES));
    check("rst.flags", 32'(dut_flags()), 32'h0);
    check("rst.first", 32'(bus.first_seen), 32'h0);
    rst = 1'b0;

    // Directed table: first sample, rise/fall, repeat, extremes.
    for (int i = 0; i < 7; i++) begin
      apply_sample(vecs[i].a);
      check($sformatf("vec%0d.b", i),     32'(bus.cmp_b),   32'(vecs[i].exp_b));
      check($sformatf("vec%0d.max", i),   32'(bus.cmp_out), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d.min", i),   32'(bus.cmp_min), 32'(vecs[i].exp_min));
      check($sformatf("vec%0d.flags", i), 32'(dut_flags()), 32'(vecs[i].exp_flags));
      check_model($sformatf("vec%0d.model", i));
    end

    // Extremes hold for any later input.
    for (int i = 0; i < 6; i++) begin
      apply_sample(4'($urandom_range(0, 15)));
      check("sat.max", 32'(bus.cmp_out), 32'hF);
      check("sat.min", 32'(bus.cmp_min), 32'h0);
      check_model("sat");
    end

    // Mid-stream reset discards history; next sample is a first sample.
    async_reset("mid");
    apply_sample(4'h6);
    check("post_rst.b",     32'(bus.cmp_b),   32'h6);
    check("post_rst.max",   32'(bus.cmp_out), 32'h6);
    check("post_rst.min",   32'(bus.cmp_min), 32'h6);
    check("post_rst.flags", 32'(dut_flags()), 32'h0);
    apply_sample(4'h6);
    check("post_rst.eq", 32'(dut_flags()), 32'b010);

    // Random stream with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        async_reset("rnd");
      end else begin
        apply_sample(4'($urandom_range(0, 15)));
        check_model("rnd");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_track.md
Name: cmp_track

Overview:
- Registered unsigned sample tracker and comparator for a narrow data stream.
- Each rising clock edge captures `cmp_in_a` and updates the following from it:
  - a one-sample history register (`cmp_b`);
  - running maximum and minimum registers;
  - one-hot magnitude flags comparing the new sample against the previous one.
- Used as a lightweight monitor or peak detector beside a datapath; purely synchronous apart from reset.

Parameters:
- CMP_WIDTH, 4, bit width of the input sample and of all data outputs (legal range 1..32).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous and active-high; forces all registers to their reset values immediately, released synchronously to the next clk edge.
- cmp_in_a  input  CMP_WIDTH  unsigned sample, captured every rising edge.
- cmp_out  output  CMP_WIDTH  registered running maximum of all samples captured since reset.
- cmp_b  output  CMP_WIDTH  registered previous sample (cmp_in_a delayed one cycle).
- cmp_min  output  CMP_WIDTH  registered running minimum of all samples captured since reset.
- cmp_gt  output  1  last captured sample > the sample before it.
- cmp_eq  output  1  last captured sample == the sample before it.
- cmp_lt  output  1  last captured sample < the sample before it.

Behaviour:
- Reset values, while rst=1, asynchronous:
  - cmp_out = 0;
  - cmp_b = 0;
  - cmp_min = all ones (2^CMP_WIDTH-1);
  - cmp_gt = cmp_eq = cmp_lt = 0;
  - internal first_seen flag = 0.
- All comparisons are unsigned and full CMP_WIDTH; no sign extension, no arithmetic overflow possible.
- Every rising clk edge with rst=0:
  - cmp_b <= cmp_in_a.
  - cmp_out <= (cmp_in_a > cmp_out) ? cmp_in_a : cmp_out.
  - cmp_min <= (cmp_in_a < cmp_min) ? cmp_in_a : cmp_min.
  - Flags compare cmp_in_a against the current cmp_b, i.e. the previous sample:
    - gt <= a>b, eq <= a==b, lt <= a<b;
    - exactly one flag is high, but only when first_seen=1.
  - first_seen <= 1.
- First sample after reset:
  - no previous sample exists, so the flags stay all 0;
  - cmp_out and cmp_min both load that sample, since it is ≥0 and ≤ all-ones.
- Latency: every output reflects the input sampled at the preceding rising edge (1 cycle). No combinational input-to-output path.
- Equal values:
  - max/min hold, value unchanged;
  - cmp_eq=1 when consecutive samples match.
- Boundaries:
  - input 2^CMP_WIDTH-1 saturates cmp_out at all ones;
  - input 0 drives cmp_min to 0;
  - both then hold until reset.
- Reset mid-operation:
  - all outputs return to reset values in the same timestep rst rises, without waiting for clk;
  - the first edge after rst falls is treated as the first sample (flags 0).
- Input X/Z is not handled; callers drive a defined value every cycle.
- Invariants after the first sample: cmp_min <= cmp_out; the flags are one-hot.

Test Plan:
- Reset check: hold rst=1 for 2 cycles with cmp_in_a=5 -> cmp_out=0, cmp_b=0, cmp_min=4'hF, all flags 0. Assert rst between clock edges -> outputs clear immediately.
- First sample: release rst, apply 1 -> after the next edge cmp_b=1, cmp_out=1, cmp_min=1, gt/eq/lt all 0.
- Rising then falling sequence, one sample per cycle:
  - sequence 1,3,2;
  - after 3: cmp_b=3, cmp_out=3, cmp_min=1, cmp_gt=1;
  - after 2: cmp_b=2, cmp_out=3, cmp_min=1, cmp_lt=1.
- Repeat: apply 2 twice -> second edge gives cmp_eq=1, cmp_out=3, cmp_min=1 unchanged.
- Extremes: apply 4'hF then 0 -> cmp_out=F and stays F; cmp_min=0 and stays 0 for any later input (e.g. 7); flags track each consecutive pair.
- Mid-stream reset: after the sequence above pulse rst, then apply 6 -> cmp_out=6, cmp_min=6, cmp_b=6, flags 0 (history discarded).
